// File: rtl/inst_mem_loader_if.sv
// Fetch and byte-loader signal bundle for inst_mem_loader.
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned WORD_BYTES = 4
);
    logic [ADDR_W-1:0]       pc;
    logic [8*WORD_BYTES-1:0] inst;
    logic                    inst_valid;
    logic                    distinct;
    logic                    loader_enable;
    logic                    loader_ready;
    logic [7:0]              loader_data;
    logic                    load_busy;
    logic                    load_done;
    logic [ADDR_W:0]         load_count;
    logic                    load_overflow;
    logic [7:0]              load_sum;

    modport master (
        output pc, loader_enable, loader_ready, loader_data,
        input  inst, inst_valid, distinct, load_busy, load_done,
               load_count, load_overflow, load_sum
    );

    modport slave (
        input  pc, loader_enable, loader_ready, loader_data,
        output inst, inst_valid, distinct, load_busy, load_done,
               load_count, load_overflow, load_sum
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory with post-reset fill sweep and a byte-serial loader.
// Optional byte checksum enabled by defining INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned WORD_BYTES = 4,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [63:0] FILL_WORD  = 64'h0000_0000_0800_0000
) (
    input logic               CLK,
    input logic               reset,
    inst_mem_loader_if.slave  bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned WORD_W = 8 * WORD_BYTES;
    localparam int unsigned BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [WORD_W-1:0] FILL      = FILL_WORD[WORD_W-1:0];
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, COLLECT, WRITE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     widx_q, widx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   inst_q, inst_d;
    logic                inst_valid_q, inst_valid_d;
    logic                distinct_q, distinct_d;
    logic [ADDR_W-1:0]   pc_prev_q, pc_prev_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic [WORD_W-1:0]   mem [DEPTH];
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [WORD_W-1:0]   mem_wdata_c;
    logic [BC_W-1:0]     lane_c;

    // Next-state, sweep/loader datapath and fetch pipeline
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        byte_cnt_d   = byte_cnt_q;
        widx_d       = widx_q;
        word_d       = word_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = FILL;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        lane_c = BIG_ENDIAN ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;

        case (state_q)
            CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr_c = clr_idx_q;
                clr_idx_d  = clr_idx_q + 1'b1;
                if (clr_idx_q == '1) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end
            end
            IDLE: begin
                if (bus.loader_enable) begin
                    state_d    = COLLECT;
                    byte_cnt_d = '0;
                    widx_d     = '0;
                    ovf_d      = 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            COLLECT: begin
                if (!bus.loader_enable) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.loader_ready) begin
                    word_d[{lane_c, 3'b000} +: 8] = bus.loader_data;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.loader_data;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!bus.loader_enable) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = COLLECT;
                    // Index stops at DEPTH; further words only flag overflow
                    if (!widx_q[ADDR_W]) begin
                        mem_we_c    = 1'b1;
                        mem_addr_c  = widx_q[ADDR_W-1:0];
                        mem_wdata_c = word_q;
                        widx_d      = widx_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        busy_d       = (state_d != IDLE);
        inst_d       = mem[bus.pc];
        inst_valid_d = (state_q == IDLE);
        distinct_d   = (bus.pc != pc_prev_q);
        pc_prev_d    = bus.pc;
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            byte_cnt_q   <= '0;
            widx_q       <= '0;
            word_q       <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            distinct_q   <= 1'b1;
            pc_prev_q    <= '1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            widx_q       <= widx_d;
            word_q       <= word_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            distinct_q   <= distinct_d;
            pc_prev_q    <= pc_prev_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Storage array; contents are rebuilt by the sweep, so no reset here
    always_ff @(posedge CLK) begin
        if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
    end

    assign bus.inst          = inst_q;
    assign bus.inst_valid    = inst_valid_q;
    assign bus.distinct      = distinct_q;
    assign bus.load_busy     = busy_q;
    assign bus.load_done     = done_q;
    assign bus.load_count    = widx_q;
    assign bus.load_overflow = ovf_q;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    assign bus.load_sum      = sum_q;
`else
    assign bus.load_sum      = 8'h00;
`endif
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: big- and little-endian instances share one stimulus.
module tb_inst_mem_loader;
    logic       CLK;
    logic       reset;
    logic [3:0] pc;
    logic       loader_enable;
    logic       loader_ready;
    logic [7:0] loader_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] FILL = 32'h0800_0000;

    inst_mem_loader_if #(.ADDR_W(4), .WORD_BYTES(4)) bus_be ();
    inst_mem_loader_if #(.ADDR_W(4), .WORD_BYTES(4)) bus_le ();

    assign bus_be.pc            = pc;
    assign bus_be.loader_enable = loader_enable;
    assign bus_be.loader_ready  = loader_ready;
    assign bus_be.loader_data   = loader_data;
    assign bus_le.pc            = pc;
    assign bus_le.loader_enable = loader_enable;
    assign bus_le.loader_ready  = loader_ready;
    assign bus_le.loader_data   = loader_data;

    inst_mem_loader #(.BIG_ENDIAN(1'b1)) u_be (.CLK(CLK), .reset(reset), .bus(bus_be.slave));
    inst_mem_loader #(.BIG_ENDIAN(1'b0)) u_le (.CLK(CLK), .reset(reset), .bus(bus_le.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        loader_data  = b;
        loader_ready = 1'b1;
        step();
        loader_ready = 1'b0;
    endtask

    // Counts cycles until load_busy drops; also notes any load_done seen meanwhile
    task automatic sweep_len(output int n, output bit done_seen);
        n = 0;
        done_seen = 1'b0;
        while (bus_be.load_busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (bus_be.load_done === 1'b1) done_seen = 1'b1;
        end
    endtask

    int n;
    bit done_seen;
    logic [7:0] exp_sum;

    initial begin
        reset = 1'b1; pc = 4'd0; loader_enable = 1'b0; loader_ready = 1'b0; loader_data = 8'h00;
        repeat (3) step();
        check("rst_inst", bus_be.inst, 0);
        check("rst_inst_valid", bus_be.inst_valid, 0);
        check("rst_distinct", bus_be.distinct, 1);
        check("rst_busy", bus_be.load_busy, 1);
        check("rst_done", bus_be.load_done, 0);
        check("rst_count", bus_be.load_count, 0);
        check("rst_overflow", bus_be.load_overflow, 0);
        check("rst_sum", bus_be.load_sum, 0);

        reset = 1'b0;
        sweep_len(n, done_seen);
        check("sweep_cycles", n, 16);

        pc = 4'd5;
        step();
        check("fill_inst", bus_be.inst, FILL);
        check("fill_valid", bus_be.inst_valid, 1);

        pc = 4'd3; step();
        check("distinct_3", bus_be.distinct, 1);
        step();
        check("distinct_3_again", bus_be.distinct, 0);
        pc = 4'd4; step();
        check("distinct_4", bus_be.distinct, 1);

        // Session 1: one full word, then abort after two bytes of the second
        loader_enable = 1'b1; step();
        check("s1_busy", bus_be.load_busy, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        step();
        check("s1_count", bus_be.load_count, 1);
        send_byte(8'hAB); send_byte(8'hCD);
        loader_enable = 1'b0;
        step();
        check("s1_done_pulse", bus_be.load_done, 1);
        check("s1_busy_off", bus_be.load_busy, 0);
        step();
        check("s1_done_clear", bus_be.load_done, 0);
        check("s1_count_held", bus_be.load_count, 1);
        check("s1_overflow", bus_be.load_overflow, 0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        exp_sum = 8'h8C;
`else
        exp_sum = 8'h00;
`endif
        check("s1_sum", bus_be.load_sum, exp_sum);
        pc = 4'd0; step();
        check("s1_mem0_be", bus_be.inst, 32'h1234_5678);
        check("s1_mem0_le", bus_le.inst, 32'h7856_3412);
        check("s1_mem0_valid", bus_be.inst_valid, 1);
        pc = 4'd1; step();
        check("s1_mem1_fill", bus_be.inst, FILL);

        // Session 2: seventeen words into a sixteen-word memory
        loader_enable = 1'b1; step();
        for (int k = 1; k <= 17; k++) begin
            send_byte(8'(k)); send_byte(8'hA0); send_byte(8'hB0); send_byte(8'(k));
            step();
        end
        check("s2_count_sat", bus_be.load_count, 16);
        check("s2_overflow", bus_be.load_overflow, 1);
        loader_enable = 1'b0; step();
        check("s2_done", bus_be.load_done, 1);
        step();
        check("s2_overflow_held", bus_be.load_overflow, 1);
        pc = 4'd15; step();
        check("s2_mem15", bus_be.inst, 32'h10A0_B010);
        pc = 4'd0; step();
        check("s2_mem0", bus_be.inst, 32'h01A0_B001);

        // Session 3: checksum wrap and per-session clearing
        loader_enable = 1'b1; step();
        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        step();
        loader_enable = 1'b0; step();
        check("s3_done", bus_be.load_done, 1);
        check("s3_count", bus_be.load_count, 1);
        check("s3_overflow_cleared", bus_be.load_overflow, 0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        exp_sum = 8'h02;
`else
        exp_sum = 8'h00;
`endif
        check("s3_sum", bus_be.load_sum, exp_sum);
        pc = 4'd0; step(); step();
        check("s3_mem0_be", bus_be.inst, 32'hFF02_0001);
        check("s3_mem0_le", bus_le.inst, 32'h0100_02FF);

        // Reset in the middle of a word: no done pulse, full sweep again
        loader_enable = 1'b1; step();
        send_byte(8'h55); send_byte(8'h66);
        reset = 1'b1; step();
        check("midrst_done", bus_be.load_done, 0);
        check("midrst_busy", bus_be.load_busy, 1);
        reset = 1'b0; loader_enable = 1'b0;
        sweep_len(n, done_seen);
        check("midrst_sweep_cycles", n, 16);
        check("midrst_no_done", done_seen, 0);
        pc = 4'd0; step(); step();
        check("midrst_mem0_fill", bus_be.inst, FILL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
